// File: rtl/fp_spi_frame_ctrl.sv
// Front-panel SPI receive controller.
// Oversamples SCLK/MOSI/CS_N in the CLK domain, assembles MSB-first bytes,
// and frames them into command/data transactions. Command bit 7 selects a
// write burst starting at the address in the low command bits. The burst
// auto-increments and wraps around the register bank.
module fp_spi_frame_ctrl #(
    parameter int          ADDR_BITS = 3,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          SCLK,
    input  logic                          MOSI,
    input  logic                          CS_N,
    output logic                          WR_STB,
    output logic [ADDR_BITS-1:0]          WR_ADDR,
    output logic [7:0]                    WR_DATA,
    output logic                          FRAME_ERR,
    output logic                          BUSY,
    output logic [8*(2**ADDR_BITS)-1:0]   REGS_OUT
);

    localparam int NREGS = 2**ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_SKIP = 2'd3
    } state_t;

    // Synchroniser, edge-detect and shifter state
    logic [1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic       sclk_prev_q, cs_prev_q;
    logic [1:0] sync_vld_q;
    logic       armed_q;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       byte_done_q;
    logic [7:0] rx_byte_q;

    // Frame FSM and register bank
    state_t                     state_q, state_d;
    logic [ADDR_BITS-1:0]       addr_ptr_q, addr_ptr_d;
    logic [NREGS-1:0][7:0]      regs_q, regs_d;
    logic                       wr_stb_q, wr_stb_d;
    logic [ADDR_BITS-1:0]       wr_addr_q, wr_addr_d;
    logic [7:0]                 wr_data_q, wr_data_d;
    logic                       frame_err_q, frame_err_d;

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, cs_fall, cs_rise, shift_en;

    assign sclk_s = sclk_sync_q[1];
    assign mosi_s = mosi_sync_q[1];
    assign cs_s   = cs_sync_q[1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    // A frame may only start once CS_N has been seen high after reset, so a
    // select line already low when reset is released is not a frame start.
    assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise   = cs_s & ~cs_prev_q;
    // Bits are only collected inside a frame; a deasserted select masks SCLK.
    assign shift_en  = sclk_rise & ~cs_s & (state_q != ST_IDLE);

    // Two-flop synchronisers plus previous-value flops for edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            sync_vld_q  <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], SCLK};
            mosi_sync_q <= {mosi_sync_q[0], MOSI};
            cs_sync_q   <= {cs_sync_q[0], CS_N};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            sync_vld_q  <= {sync_vld_q[0], 1'b1};
            armed_q     <= armed_q | (sync_vld_q[1] & cs_s);
        end
    end

    // Shift register, bit counter and one-cycle byte-complete pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            rx_byte_q   <= 8'h00;
        end else begin
            byte_done_q <= shift_en && (bit_cnt_q == 3'd7);
            if (cs_fall || cs_rise) begin
                bit_cnt_q <= 3'd0;
            end else if (shift_en) begin
                shift_q   <= {shift_q[6:0], mosi_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_byte_q <= {shift_q[6:0], mosi_s};
                end
            end
        end
    end

    // FSM, write strobe and register bank state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            addr_ptr_q  <= '0;
            regs_q      <= {NREGS{RESET_VAL}};
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_ptr_q  <= addr_ptr_d;
            regs_q      <= regs_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state: framing decisions, burst writes, CS_N abort handling
    always_comb begin
        state_d     = state_q;
        addr_ptr_d  = addr_ptr_q;
        regs_d      = regs_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (byte_done_q) begin
                    if (rx_byte_q[7]) begin
                        state_d    = ST_DATA;
                        addr_ptr_d = rx_byte_q[ADDR_BITS-1:0];
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_DATA: begin
                if (byte_done_q) begin
                    regs_d[addr_ptr_q] = rx_byte_q;
                    wr_stb_d           = 1'b1;
                    wr_addr_d          = addr_ptr_q;
                    wr_data_d          = rx_byte_q;
                    addr_ptr_d         = addr_ptr_q + 1'b1;
                end
            end
            default: ;  // ST_SKIP: bytes are consumed without effect
        endcase

        // Deselect ends the frame; a completed byte on the same cycle still
        // lands above, and only a partial byte counts as an error.
        if (cs_rise && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            if (bit_cnt_q != 3'd0) frame_err_d = 1'b1;
        end
    end

    assign WR_STB    = wr_stb_q;
    assign WR_ADDR   = wr_addr_q;
    assign WR_DATA   = wr_data_q;
    assign FRAME_ERR = frame_err_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign REGS_OUT  = regs_q;

endmodule

// File: tb/tb_fp_spi_frame_ctrl.sv
// Bench for fp_spi_frame_ctrl: SPI driver tasks feed a reference register
// model and an expected-write queue; a monitor pops the queue on each strobe.
module tb_fp_spi_frame_ctrl;

  localparam int AB = 3;
  localparam int NR = 2**AB;

  logic            CLK, RST, SCLK, MOSI, CS_N;
  logic            WR_STB, FRAME_ERR, BUSY;
  logic [AB-1:0]   WR_ADDR;
  logic [7:0]      WR_DATA;
  logic [8*NR-1:0] REGS_OUT;

  fp_spi_frame_ctrl #(.ADDR_BITS(AB), .RESET_VAL(8'h00)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .MOSI(MOSI), .CS_N(CS_N),
    .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .FRAME_ERR(FRAME_ERR), .BUSY(BUSY), .REGS_OUT(REGS_OUT)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int rise_cyc = 0;
  bit lat_on = 0;
  int half = 4;

  // scoreboard: {addr, data} of expected writes
  logic [AB+7:0] exp_q[$];
  logic [7:0]    mdl_regs [NR];
  logic [AB-1:0] mdl_ptr;
  bit            mdl_write;

  always @(posedge CLK) cyc++;

  // monitor: sampled 1ns after the active edge
  always @(posedge CLK) begin
    #1;
    if (FRAME_ERR === 1'b1) err_cnt++;
    if (WR_STB === 1'b1) begin
      logic [AB+7:0] e;
      stb_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write", WR_ADDR, WR_DATA);
      end else begin
        e = exp_q.pop_front();
        if ({WR_ADDR, WR_DATA} !== e) begin
          errors++;
          $display("FAIL write_sb: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   WR_ADDR, WR_DATA, e[AB+7:8], e[7:0]);
        end
        checks++;
        if (REGS_OUT[8*e[AB+7:8] +: 8] !== e[7:0]) begin
          errors++;
          $display("FAIL regs_at_stb: got %02h, required %02h", REGS_OUT[8*e[AB+7:8] +: 8], e[7:0]);
        end
      end
      if (lat_on) begin
        lat_on = 0;
        checks++;
        if ((cyc - rise_cyc) < 4 || (cyc - rise_cyc) > 5) begin
          errors++;
          $display("FAIL latency: got %0d CLK, required 4 (or 5)", cyc - rise_cyc);
        end
      end
    end
  end

  function automatic logic [8*NR-1:0] model_flat();
    logic [8*NR-1:0] v;
    for (int k = 0; k < NR; k++) v[8*k +: 8] = mdl_regs[k];
    return v;
  endfunction

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      MOSI = b[7-i];
      wait_clk(half);
      SCLK = 1'b1;
      if (i == 7) rise_cyc = cyc;
      wait_clk(half);
      SCLK = 1'b0;
    end
  endtask

  task automatic cs_low();
    CS_N = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(3);
    CS_N = 1'b1;
    wait_clk(6);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    mdl_write = b[7];
    mdl_ptr = b[AB-1:0];
    spi_bits(b, 8);
  endtask

  task automatic send_data(input logic [7:0] b);
    if (mdl_write) begin
      exp_q.push_back({mdl_ptr, b});
      mdl_regs[mdl_ptr] = b;
      mdl_ptr = mdl_ptr + 1'b1;
    end
    spi_bits(b, 8);
  endtask

  task automatic clear_counts();
    stb_cnt = 0;
    err_cnt = 0;
  endtask

  // tests
  task automatic test_reset();
    RST = 1'b1; SCLK = 1'b0; MOSI = 1'b0; CS_N = 1'b1;
    for (int k = 0; k < NR; k++) mdl_regs[k] = 8'h00;
    wait_clk(3);
    checks++;
    if ({WR_STB, FRAME_ERR, BUSY} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got stb/err/busy=%b, required 000", {WR_STB, FRAME_ERR, BUSY});
    end
    checks++;
    if ({WR_ADDR, WR_DATA} !== '0) begin
      errors++;
      $display("FAIL reset_wr: got addr=%0d data=%02h, required 0/00", WR_ADDR, WR_DATA);
    end
    RST = 1'b0;
    wait_clk(4);
    checks++;
    if (REGS_OUT !== model_flat() || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got %h busy=%b, required %h busy=0", REGS_OUT, BUSY, model_flat());
    end
  endtask

  task automatic test_single_write();
    clear_counts();
    cs_low();
    send_cmd(8'h82);
    send_data(8'hA5);
    cs_high();
    checks++;
    if (stb_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL single_counts: got stb=%0d err=%0d, required 1/0", stb_cnt, err_cnt);
    end
    checks++;
    if (WR_ADDR !== 3'd2 || WR_DATA !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold: got addr=%0d data=%02h, required 2/a5", WR_ADDR, WR_DATA);
    end
    checks++;
    if (REGS_OUT !== 64'h0000_0000_00A5_0000 || REGS_OUT !== model_flat()) begin
      errors++;
      $display("FAIL single_regs: got %h, required %h", REGS_OUT, model_flat());
    end
  endtask

  task automatic test_burst_wrap();
    clear_counts();
    cs_low();
    send_cmd(8'h86);
    send_data(8'h11);
    send_data(8'h22);
    send_data(8'h33);
    cs_high();
    checks++;
    if (stb_cnt != 3 || err_cnt != 0) begin
      errors++;
      $display("FAIL burst_counts: got stb=%0d err=%0d, required 3/0", stb_cnt, err_cnt);
    end
    checks++;
    if (WR_ADDR !== 3'd0 || WR_DATA !== 8'h33) begin
      errors++;
      $display("FAIL burst_last: got addr=%0d data=%02h, required 0/33", WR_ADDR, WR_DATA);
    end
    checks++;
    if (REGS_OUT !== model_flat()) begin
      errors++;
      $display("FAIL burst_regs: got %h, required %h", REGS_OUT, model_flat());
    end
  endtask

  task automatic test_non_write();
    clear_counts();
    cs_low();
    send_cmd(8'h05);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_frame: got %b, required 1", BUSY);
    end
    send_data(8'hFF);
    wait_clk(3);
    CS_N = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_1: got %b, required 1", BUSY);
    end
    @(posedge CLK); @(posedge CLK); #1;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_3: got %b, required 0", BUSY);
    end
    wait_clk(4);
    checks++;
    if (stb_cnt != 0 || err_cnt != 0 || REGS_OUT !== model_flat()) begin
      errors++;
      $display("FAIL non_write: got stb=%0d err=%0d regs=%h, required 0/0 %h",
               stb_cnt, err_cnt, REGS_OUT, model_flat());
    end
  endtask

  task automatic test_abort();
    logic [7:0] partial;
    clear_counts();
    partial = 8'($urandom_range(0, 255));
    cs_low();
    send_cmd(8'h81);
    spi_bits(partial, 5);
    cs_high();
    checks++;
    if (err_cnt != 1 || stb_cnt != 0) begin
      errors++;
      $display("FAIL abort_counts: got err=%0d stb=%0d, required 1/0", err_cnt, stb_cnt);
    end
    checks++;
    if (REGS_OUT !== model_flat()) begin
      errors++;
      $display("FAIL abort_regs: got %h, required %h", REGS_OUT, model_flat());
    end
    clear_counts();
    cs_low();
    send_cmd(8'h81);
    send_data(8'h3C);
    cs_high();
    checks++;
    if (REGS_OUT[15:8] !== 8'h3C || REGS_OUT !== model_flat() || stb_cnt != 1 || err_cnt != 0) begin
      errors++;
      $display("FAIL abort_recover: got reg1=%02h stb=%0d err=%0d, required 3c/1/0",
               REGS_OUT[15:8], stb_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    clear_counts();
    cs_low();
    send_cmd(8'h81);
    spi_bits(8'hE0, 3);
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < NR; k++) mdl_regs[k] = 8'h00;
    exp_q.delete();
    mdl_write = 0;
    wait_clk(3);
    RST = 1'b0;
    wait_clk(4);
    spi_bits(8'h9A, 8);
    wait_clk(6);
    checks++;
    if (stb_cnt != 0 || REGS_OUT !== model_flat() || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got stb=%0d regs=%h busy=%b, required 0 %h 0",
               stb_cnt, REGS_OUT, BUSY, model_flat());
    end
    CS_N = 1'b1;
    wait_clk(6);
    clear_counts();
    cs_low();
    send_cmd(8'h83);
    send_data(8'h77);
    cs_high();
    checks++;
    if (stb_cnt != 1 || REGS_OUT !== model_flat() || REGS_OUT[31:24] !== 8'h77) begin
      errors++;
      $display("FAIL rst_recover: got stb=%0d regs=%h, required 1 %h", stb_cnt, REGS_OUT, model_flat());
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    half = 3;
    cs_low();
    send_cmd(8'h80);
    lat_on = 1;
    for (int i = 0; i < 16; i++) send_data(8'($urandom_range(0, 255)));
    cs_high();
    half = 4;
    checks++;
    if (stb_cnt != 16 || err_cnt != 0 || lat_on) begin
      errors++;
      $display("FAIL b2b_counts: got stb=%0d err=%0d lat_pending=%0d, required 16/0/0",
               stb_cnt, err_cnt, lat_on);
    end
    checks++;
    if (REGS_OUT !== model_flat()) begin
      errors++;
      $display("FAIL b2b_regs: got %h, required %h", REGS_OUT, model_flat());
    end
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_write = 0;
    mdl_ptr = '0;
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_non_write();
    test_abort();
    test_reset_midframe();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_spi_frame_ctrl.md
Name: fp_spi_frame_ctrl

Overview:
Front-panel SPI receive controller. It samples the host's SCLK/MOSI/CS_N in the system clock domain and shifts bits into an 8-bit receive byte. It frames the bytes into command/data transactions and writes a bank of 8-bit front-panel registers (LED, display and control latches). This block sits between the panel connector pins and the panel output drivers, and it sequences byte assembly, addressing and register write strobes.

Parameters:
ADDR_BITS, 3, register address width; the bank holds NREGS = 2**ADDR_BITS registers.
RESET_VAL, 8'h00, reset value of every register in the bank.

Ports:
CLK  input  1  system clock; all logic is on its rising edge.
RST  input  1  asynchronous, active-high reset.
SCLK  input  1  SPI clock from the host, asynchronous to CLK, mode 0; MOSI is sampled on the SCLK rising edge.
MOSI  input  1  SPI serial data, MSB first.
CS_N  input  1  SPI chip select, active low, asynchronous to CLK.
WR_STB  output  1  one-CLK pulse when a register is written.
WR_ADDR  output  ADDR_BITS  address of the current or last write.
WR_DATA  output  8  data of the current or last write.
FRAME_ERR  output  1  one-CLK pulse when CS_N rises mid-byte.
BUSY  output  1  high while a frame is active (synchronised CS_N low).
REGS_OUT  output  8*NREGS  register bank, flattened; reg k occupies bits [8k+7:8k].

Behaviour:
- Reset (asynchronous): all registers = RESET_VAL; WR_STB=0, WR_ADDR=0, WR_DATA=0, FRAME_ERR=0, BUSY=0; bit count=0; state=IDLE; synchronisers cleared to SCLK=0, MOSI=0, CS_N=1.
- Synchronisation: SCLK, MOSI and CS_N each pass through a 2-FF synchroniser.
  - SCLK rise = sync'd SCLK is 1 and its previous value was 0 (one-CLK pulse).
  - Timing requirement: SCLK high and low time ≥ 3 CLK periods each; MOSI is stable ≥ 3 CLK around the SCLK rise.
- Shifter: on an SCLK rise with sync'd CS_N = 0, shift_reg <= {shift_reg[6:0], MOSI_s} and bit count increments (3-bit, wraps 7→0).
  - When the bit count wraps to 0, a byte is complete; byte_done pulses on the following CLK with the assembled byte.
- State machine:
  - IDLE: BUSY=0. On sync'd CS_N falling → CMD; bit count cleared.
  - CMD: on byte_done, if byte[7]=1 → DATA with addr_ptr=byte[ADDR_BITS-1:0]; else → SKIP. Bits [6:ADDR_BITS] are ignored.
  - DATA: on each byte_done:
    - REGS_OUT[addr_ptr] <= byte; WR_STB=1; WR_ADDR=addr_ptr; WR_DATA=byte, all on the same CLK edge.
    - addr_ptr then increments and wraps modulo NREGS (auto-increment burst).
  - SKIP: bytes are consumed and no writes occur.
  - Any state: sync'd CS_N rising → IDLE. If the bit count ≠ 0 at that point, FRAME_ERR pulses for one CLK and the partial byte is discarded; the bit count is cleared.
- Latency: the write is visible on REGS_OUT and WR_STB exactly 4 CLK after the raw SCLK edge that carries the 8th bit (2 sync + 1 edge detect + 1 byte_done/write), ±1 CLK for metastability resolution.
- BUSY = (state ≠ IDLE).
- WR_ADDR and WR_DATA hold their values between strobes.
- Simultaneous events:
  - A byte completing on the same CLK as the CS_N rise: the write still occurs, FRAME_ERR=0, then the state goes to IDLE.
  - An SCLK rise while sync'd CS_N = 1 is ignored.
- A CS_N re-assertion without any SCLK edges produces no write and no error.
- Reset mid-frame aborts immediately. After reset is released, the block waits for a fresh CS_N falling edge; CS_N already low at that point is not treated as a frame start.

Test Plan:
- Single write: CS_N low, send 8'h82 then 8'hA5, CS_N high → WR_STB pulses once with WR_ADDR=2, WR_DATA=8'hA5; REGS_OUT[23:16]=8'hA5, all other registers 8'h00; FRAME_ERR never pulses.
- Burst with wrap: send 8'h86, 8'h11, 8'h22, 8'h33 → three WR_STB pulses; reg6=8'h11, reg7=8'h22, reg0=8'h33; final WR_ADDR=0.
- Non-write frame: send 8'h05, 8'hFF → no WR_STB; REGS_OUT unchanged; BUSY high during the frame, low 3 CLK after CS_N rises.
- Aborted byte: send 8'h81, then 5 bits of data, CS_N high → one FRAME_ERR pulse, no WR_STB, reg1 unchanged; a following frame 8'h81, 8'h3C writes reg1=8'h3C.
- Reset mid-frame: assert RST after the command byte plus 3 data bits, release with CS_N still low, send 8 more bits → all registers 8'h00, no WR_STB; normal writes work after the next CS_N high→low transition.
- Latency check: measure CLK edges from the 8th raw SCLK rise to WR_STB → 4 CLK (tolerance +1); SCLK at minimum 3-CLK high/low timing → every byte of a 16-byte burst is received correctly.
